// File: rtl/lf_pkg.sv
// lf_pkg: shared types and constants for the line-follow run-mode controller.
//   lf_state_e  : run-mode states, encoding visible on the debug LED port
//   NEUTRAL     : servo command meaning "wheel stopped"
//   LEFT/RIGHT  : last-seen line side
//   clamp_servo : saturate a signed mix result into the 0..255 servo range
// Optional feature macro used by the users of this package: LF_SLEW_LIMIT_EN.
package lf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FOLLOW = 3'd2,
    SEARCH = 3'd3,
    HALT   = 3'd4
  } lf_state_e;

  localparam int unsigned SERVO_W = 8;
  localparam int unsigned PID_W   = 13;
  // Mix arithmetic width: sign-extended pid plus headroom for base +/- p.
  localparam int unsigned MIX_W   = 14;

  localparam logic [SERVO_W-1:0] NEUTRAL = 8'd128;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam logic signed [MIX_W-1:0] SERVO_MIN_S = 14'sd0;
  localparam logic signed [MIX_W-1:0] SERVO_MAX_S = 14'sd255;

  function automatic logic [SERVO_W-1:0] clamp_servo(input logic signed [MIX_W-1:0] v);
    logic [SERVO_W-1:0] res;
    if (v < SERVO_MIN_S)      res = '0;
    else if (v > SERVO_MAX_S) res = '1;
    else                      res = v[SERVO_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/lf_slew_sat.sv
// lf_slew_sat: one wheel's output stage. Clamps a signed target to 0..255 and
// registers it on i_en. With LF_SLEW_LIMIT_EN defined, the registered command
// moves toward the clamped target by at most SLEW_STEP per enabled cycle unless
// i_bypass requests an immediate jump.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (command -> NEUTRAL)
//   i_en         update strobe (the 1 kHz tick)
//   i_bypass     (LF_SLEW_LIMIT_EN only) take the target without slewing
//   i_target     signed target command before saturation
//   o_cmd        registered 8-bit servo command
module lf_slew_sat
  import lf_pkg::*;
`ifdef LF_SLEW_LIMIT_EN
#(
  parameter int unsigned SLEW_STEP = 4
)
`endif
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
`ifdef LF_SLEW_LIMIT_EN
  input  logic                    i_bypass,
`endif
  input  logic signed [MIX_W-1:0] i_target,
  output logic [SERVO_W-1:0]      o_cmd
);

  logic [SERVO_W-1:0] w_tgt;
  logic [SERVO_W-1:0] w_next;
  logic [SERVO_W-1:0] r_cmd;

  assign w_tgt = clamp_servo(i_target);

`ifdef LF_SLEW_LIMIT_EN
  localparam int unsigned DW = SERVO_W + 2;
  localparam logic signed [DW-1:0] STEP_S = DW'(SLEW_STEP);

  logic signed [DW-1:0] w_diff;

  always_comb begin
    w_diff = $signed({2'b00, w_tgt}) - $signed({2'b00, r_cmd});
    if (i_bypass)             w_next = w_tgt;
    else if (w_diff > STEP_S)  w_next = r_cmd + SERVO_W'(SLEW_STEP);
    else if (w_diff < -STEP_S) w_next = r_cmd - SERVO_W'(SLEW_STEP);
    else                      w_next = w_tgt;
  end
`else
  assign w_next = w_tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_cmd <= NEUTRAL;
    else if (i_en) r_cmd <= w_next;
  end

  assign o_cmd = r_cmd;

endmodule

// File: rtl/line_follow_sequencer.sv
// line_follow_sequencer: run-mode controller between the PID datapath and the
// servo PWM stage. Sequences IDLE -> ARM -> FOLLOW <-> SEARCH -> HALT and turns
// pid_output/sensors into per-wheel servo commands. Everything except the
// start/stop edge detector advances only on tick.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   tick        1 kHz one-cycle strobe
//   start_stop  synchronised button level, rising edge toggles run/stop
//   sensors     line sensors, bit3 leftmost, bit0 rightmost, 1 = line
//   pid_output  signed steering correction, positive = steer right
//   servo_l/r   registered wheel commands, NEUTRAL = stop
//   state       current state encoding (debug LEDs)
//   lost        high while in SEARCH or HALT
// Optional: define LF_SLEW_LIMIT_EN to slew-limit commands in FOLLOW/SEARCH.
module line_follow_sequencer
  import lf_pkg::*;
#(
  parameter int unsigned BASE_SPEED   = 180,
  parameter int unsigned PID_SHIFT    = 4,
  parameter int unsigned ARM_TICKS    = 500,
  parameter int unsigned LOST_TICKS   = 50,
  parameter int unsigned SEARCH_TICKS = 2000,
  parameter int unsigned SEARCH_SPEED = 40
`ifdef LF_SLEW_LIMIT_EN
  ,
  parameter int unsigned SLEW_STEP    = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_stop,
  input  logic [3:0]         sensors,
  input  logic [PID_W-1:0]   pid_output,
  output logic [SERVO_W-1:0] servo_l,
  output logic [SERVO_W-1:0] servo_r,
  output logic [2:0]         state,
  output logic               lost
);

  // One counter serves both ARM and SEARCH, so size it for the larger limit.
  localparam int unsigned CNT_MAX = (SEARCH_TICKS > ARM_TICKS) ? SEARCH_TICKS : ARM_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned LOST_W  = $clog2(LOST_TICKS);

  localparam logic signed [MIX_W-1:0] BASE_S  = MIX_W'(BASE_SPEED);
  localparam logic signed [MIX_W-1:0] SPIN_LO = MIX_W'(NEUTRAL) - MIX_W'(SEARCH_SPEED);
  localparam logic signed [MIX_W-1:0] SPIN_HI = MIX_W'(NEUTRAL) + MIX_W'(SEARCH_SPEED);
  localparam logic signed [MIX_W-1:0] NEUT_S  = MIX_W'(NEUTRAL);

  lf_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [LOST_W-1:0]  r_lost_cnt, w_lost_cnt_nxt, w_lost_inc;
  logic               r_side, w_side_nxt;
  logic               r_lost;
  logic               r_stop_pend;
  logic               r_prev_ss;
  logic               w_ss_rise;

  logic signed [MIX_W-1:0] w_pid_ext;
  logic signed [MIX_W-1:0] w_p;
  logic signed [MIX_W-1:0] w_tgt_l, w_tgt_r;

  assign w_ss_rise = start_stop & ~r_prev_ss;

  assign w_pid_ext = {pid_output[PID_W-1], pid_output};
  assign w_p       = w_pid_ext >>> PID_SHIFT;

  assign w_cnt_inc  = (r_cnt == '1)      ? r_cnt      : r_cnt + CNT_W'(1);
  assign w_lost_inc = (r_lost_cnt == '1) ? r_lost_cnt : r_lost_cnt + LOST_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lost_cnt_nxt = r_lost_cnt;

    if (sensors[3])      w_side_nxt = LEFT;
    else if (sensors[0]) w_side_nxt = RIGHT;
    else                 w_side_nxt = r_side;

    if (r_stop_pend) begin
      // A pending button edge overrides every other transition this tick.
      if (r_state == IDLE) begin
        w_state_nxt = ARM;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      unique case (r_state)
        IDLE: ;
        ARM: begin
          if (r_cnt == CNT_W'(ARM_TICKS - 1)) begin
            w_state_nxt    = FOLLOW;
            w_lost_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        FOLLOW: begin
          if (sensors == 4'b0000) begin
            if (r_lost_cnt == LOST_W'(LOST_TICKS - 1)) begin
              w_state_nxt = SEARCH;
              w_cnt_nxt   = '0;
            end else begin
              w_lost_cnt_nxt = w_lost_inc;
            end
          end else begin
            w_lost_cnt_nxt = '0;
          end
        end
        SEARCH: begin
          if (sensors != 4'b0000) begin
            w_state_nxt    = FOLLOW;
            w_lost_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(SEARCH_TICKS - 1)) begin
            w_state_nxt = HALT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        HALT: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output targets follow the state being entered, so a transition and its
  // new command land on the same tick.
  always_comb begin
    w_tgt_l = NEUT_S;
    w_tgt_r = NEUT_S;
    if (w_state_nxt == FOLLOW) begin
      w_tgt_l = BASE_S + w_p;
      w_tgt_r = BASE_S - w_p;
    end else if (w_state_nxt == SEARCH) begin
      if (w_side_nxt == LEFT) begin
        w_tgt_l = SPIN_LO;
        w_tgt_r = SPIN_HI;
      end else begin
        w_tgt_l = SPIN_HI;
        w_tgt_r = SPIN_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lost_cnt  <= '0;
      r_side      <= LEFT;
      r_lost      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_prev_ss   <= 1'b0;
    end else begin
      r_prev_ss   <= start_stop;
      r_stop_pend <= w_ss_rise | (r_stop_pend & ~tick);
      if (tick) begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_lost_cnt <= w_lost_cnt_nxt;
        r_side     <= w_side_nxt;
        r_lost     <= (w_state_nxt == SEARCH) || (w_state_nxt == HALT);
      end
    end
  end

`ifdef LF_SLEW_LIMIT_EN
  logic w_bypass;
  assign w_bypass = !((w_state_nxt == FOLLOW) || (w_state_nxt == SEARCH));
`endif

  lf_slew_sat
`ifdef LF_SLEW_LIMIT_EN
    #(.SLEW_STEP(SLEW_STEP))
`endif
    u_slew_l (
      .clk      (clk),
      .rst_n    (rst),
      .i_en     (tick),
`ifdef LF_SLEW_LIMIT_EN
      .i_bypass (w_bypass),
`endif
      .i_target (w_tgt_l),
      .o_cmd    (servo_l)
    );

  lf_slew_sat
`ifdef LF_SLEW_LIMIT_EN
    #(.SLEW_STEP(SLEW_STEP))
`endif
    u_slew_r (
      .clk      (clk),
      .rst_n    (rst),
      .i_en     (tick),
`ifdef LF_SLEW_LIMIT_EN
      .i_bypass (w_bypass),
`endif
      .i_target (w_tgt_r),
      .o_cmd    (servo_r)
    );

  assign state = r_state;
  assign lost  = r_lost;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer. Expected values are hand-computed;
// those that differ under LF_SLEW_LIMIT_EN are selected with the same macro.
module tb_line_follow_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start_stop;
  logic [3:0]  sensors;
  logic [12:0] pid_output;
  logic [7:0]  servo_l, servo_r;
  logic [2:0]  state;
  logic        lost;

  int checks = 0;
  int errors = 0;

  line_follow_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_stop (start_stop),
    .sensors    (sensors),
    .pid_output (pid_output),
    .servo_l    (servo_l),
    .servo_r    (servo_r),
    .state      (state),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each tick is one cycle wide; returns at the negedge after the tick edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic press();
    @(negedge clk); start_stop = 1'b1;
    @(negedge clk); start_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int l, input int r, input int st, input int lo);
    chk({tag, "_l"},     32'(servo_l), 32'(l));
    chk({tag, "_r"},     32'(servo_r), 32'(r));
    chk({tag, "_state"}, 32'(state),   32'(st));
    chk({tag, "_lost"},  32'(lost),    32'(lo));
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start_stop = 1'b0;
    sensors = 4'b0110; pid_output = 13'd0;
    repeat (3) @(negedge clk);
    chk_out("reset", 128, 128, 0, 0);
    rst = 1'b1;

    // IDLE -> ARM on first tick after the button edge.
    press();
    tick_n(1);
    chk_out("arm", 128, 128, 1, 0);
    tick_n(499);
    chk("arm_499_state", 32'(state), 32'd1);
    tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("follow_enter", 132, 132, 2, 0);
    tick_n(12);
    chk_out("follow_settle", 180, 180, 2, 0);
`else
    chk_out("follow_enter", 180, 180, 2, 0);
`endif

    // Steering mix: p = 20.
    pid_output = 13'd320;
    tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("mix_pos", 184, 176, 2, 0);
`else
    chk_out("mix_pos", 200, 160, 2, 0);
`endif
    for (int k = 1; k <= 4; k++) begin
      tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
      chk("ramp_l", 32'(servo_l), 32'(184 + 4 * k));
      chk("ramp_r", 32'(servo_r), 32'(176 - 4 * k));
`else
      chk("hold_l", 32'(servo_l), 32'd200);
      chk("hold_r", 32'(servo_r), 32'd160);
`endif
    end

    // p = -256: both wheels clamp.
    pid_output = 13'h1000;
    tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("mix_neg_step", 196, 164, 2, 0);
    tick_n(49);
`endif
    chk_out("mix_clamp", 0, 255, 2, 0);

    // Line last seen on the left, then darkness.
    pid_output = 13'd0;
    sensors = 4'b1000;
    tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("left_seen", 4, 251, 2, 0);
`else
    chk_out("left_seen", 180, 180, 2, 0);
`endif
    sensors = 4'b0000;
    tick_n(49);
    chk("dark_49_state", 32'(state), 32'd2);
    chk("dark_49_lost",  32'(lost),  32'd0);
    tick_n(1);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("search_left", 176, 176, 3, 1);
`else
    chk_out("search_left", 88, 168, 3, 1);
`endif

    // Rightmost sensor reacquires the line.
    sensors = 4'b0001;
    tick_n(1);
    chk_out("reacquire", 180, 180, 2, 0);

    // Lost again, last side RIGHT -> mirrored spin.
    sensors = 4'b0000;
    tick_n(50);
`ifdef LF_SLEW_LIMIT_EN
    chk_out("search_right", 176, 176, 3, 1);
`else
    chk_out("search_right", 168, 88, 3, 1);
`endif

    // Search timeout.
    tick_n(1999);
    chk("search_1999_state", 32'(state), 32'd3);
    tick_n(1);
    chk_out("halt", 128, 128, 4, 1);
    press();
    tick_n(1);
    chk_out("halt_to_idle", 128, 128, 0, 0);

    // Button edge on the same tick the lost counter hits its limit.
    press();
    tick_n(1);
    sensors = 4'b0110;
    tick_n(500);
    chk("follow2_state", 32'(state), 32'd2);
    sensors = 4'b0000;
    tick_n(49);
    chk("follow2_dark_state", 32'(state), 32'd2);
    press();
    tick_n(1);
    chk_out("stop_beats_search", 128, 128, 0, 0);

    // Asynchronous reset mid-run.
    press();
    tick_n(1);
    sensors = 4'b0110;
    tick_n(501);
`ifdef LF_SLEW_LIMIT_EN
    chk("pre_rst_l", 32'(servo_l), 32'd136);
`else
    chk("pre_rst_l", 32'(servo_l), 32'd180);
`endif
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 128, 128, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
